// File: rtl/cpu_defs.sv
// ============================================================================
// Module  : cpu_defs (package)
// Purpose : CPU-wide constants shared by the decoder, the datapath and the
//           register file: register count, data/address widths and the
//           hard-wired zero register index.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package cpu_defs;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int REG_NUM  = 32;
  localparam int ZERO_REG = 0;

  // Width of the display-board write counter.
  localparam int CNT_W    = 16;

endpackage : cpu_defs

`default_nettype wire

// File: rtl/reg_file.sv
// ============================================================================
// Module  : reg_file
// Purpose : CPU general-purpose register file. Two combinational read ports
//           plus a combinational debug/display read port, one synchronous
//           write port, and a count of committed writes. Register 0 is a
//           constant zero and is never stored.
// Ports   : clk       - clock, all state changes on rising edge
//           rst       - asynchronous active-high reset
//           ra1/rd1   - read port 1 address / data (rs)
//           ra2/rd2   - read port 2 address / data (rt)
//           we/wa/wd  - write enable / address / data
//           dbg_addr  - debug read address
//           dbg_data  - debug read data
//           wr_count  - committed writes since reset (wraps at 16 bits)
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module reg_file #(
  parameter int DATA_W = cpu_defs::DATA_W,
  parameter int ADDR_W = cpu_defs::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [15:0]       wr_count
);

  localparam int            REG_NUM = 2 ** ADDR_W;
  localparam [ADDR_W-1:0]   c_zero  = ADDR_W'(cpu_defs::ZERO_REG);

  // Only registers 1..REG_NUM-1 are stored; register 0 reads as a constant.
  logic [DATA_W-1:0] r_regs [1:REG_NUM-1];
  logic [15:0]       r_wr_count;
  logic              w_commit;

  // A write to register 0 is dropped entirely. Gating on 'we' first keeps an
  // unknown 'wa' from producing a commit while writes are disabled.
  assign w_commit = we && (wa != c_zero);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i < REG_NUM; i++) begin
        r_regs[i] <= '0;
      end
      r_wr_count <= '0;
    end else if (w_commit) begin
      for (int i = 1; i < REG_NUM; i++) begin
        if (wa == ADDR_W'(i)) begin
          r_regs[i] <= wd;
        end
      end
      r_wr_count <= r_wr_count + 16'd1;  // natural wrap at 0xFFFF
    end
  end

  // Combinational reads, no write bypass: a same-cycle write becomes visible
  // only after the clock edge.
  assign rd1      = (ra1      == c_zero) ? '0 : r_regs[ra1];
  assign rd2      = (ra2      == c_zero) ? '0 : r_regs[ra2];
  assign dbg_data = (dbg_addr == c_zero) ? '0 : r_regs[dbg_addr];
  assign wr_count = r_wr_count;

endmodule : reg_file

`default_nettype wire

// File: tb/tb_reg_file.sv
// ============================================================================
// Module  : tb_reg_file
// Purpose : Self-checking bench for reg_file against an array-based
//           reference model of the register file rules.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_reg_file;

  logic        clk;
  logic        rst;
  logic [4:0]  ra1, ra2, wa, dbg_addr;
  logic [31:0] rd1, rd2, wd, dbg_data;
  logic        we;
  logic [15:0] wr_count;

  // Reference model: plain register array plus a write counter.
  logic [31:0] m_regs [0:31];
  int unsigned m_count;

  int errors;
  int checks;

  reg_file dut (
    .clk      (clk),
    .rst      (rst),
    .ra1      (ra1),
    .ra2      (ra2),
    .rd1      (rd1),
    .rd2      (rd2),
    .we       (we),
    .wa       (wa),
    .wd       (wd),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data),
    .wr_count (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    m_count = 0;
  endtask

  // Apply the architectural write rule to the model at a clock edge.
  task automatic model_edge(input logic w, input logic [4:0] a, input logic [31:0] d);
    if (w === 1'b1 && a !== 5'd0) begin
      m_regs[a] = d;
      m_count   = (m_count + 1) % 65536;
    end
  endtask

  // Drive a write at the falling edge, then step past the rising edge.
  task automatic do_write(input logic w, input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    we = w; wa = a; wd = d;
    @(posedge clk);
    #1;
    model_edge(w, a, d);
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic check_all_regs(input string tag);
    for (int i = 0; i < 32; i++) begin
      dbg_addr = 5'(i);
      #1;
      chk(tag, dbg_data, m_regs[i]);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    model_reset();
    rst = 1'b1;
    we = 1'b1; wa = 5'd3; wd = 32'hDEAD_BEEF;
    ra1 = 5'd3; ra2 = 5'd3; dbg_addr = 5'd3;

    // Writes attempted while reset is held must be lost.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hold_reg3", rd1, 32'h0);
    chk("rst_hold_cnt", {16'h0, wr_count}, 32'h0);

    @(negedge clk);
    we = 1'b0;
    rst = 1'b0;

    // After reset: every address reads zero on all three ports.
    for (int i = 0; i < 32; i++) begin
      ra1 = 5'(i); ra2 = 5'(i); dbg_addr = 5'(i);
      #1;
      chk("reset_rd1", rd1, 32'h0);
      chk("reset_rd2", rd2, 32'h0);
      chk("reset_dbg", dbg_data, 32'h0);
    end
    chk("reset_cnt", {16'h0, wr_count}, 32'h0);

    // LUI-style upper-immediate value stored bit-exact.
    ra1 = 5'd8;
    do_write(1'b1, 5'd8, 32'h1234_0000);
    #1;
    chk("lui_rd1", rd1, 32'h1234_0000);
    chk("lui_cnt", {16'h0, wr_count}, 32'd1);

    // Write to register 0 is discarded.
    ra2 = 5'd0;
    do_write(1'b1, 5'd0, 32'hFFFF_FFFF);
    #1;
    chk("zero_rd2", rd2, 32'h0);
    chk("zero_cnt", {16'h0, wr_count}, 32'd1);

    // Read-during-write: old value before the edge, new after.
    do_write(1'b1, 5'd5, 32'h11);
    @(negedge clk);
    ra1 = 5'd5; ra2 = 5'd5; wa = 5'd5; wd = 32'h22; we = 1'b1;
    #1;
    chk("rdw_before_rd1", rd1, 32'h11);
    chk("rdw_before_rd2", rd2, 32'h11);
    @(posedge clk);
    #1;
    model_edge(1'b1, 5'd5, 32'h22);
    chk("rdw_after_rd1", rd1, 32'h22);
    chk("rdw_after_rd2", rd2, 32'h22);
    @(negedge clk);
    we = 1'b0;

    // Unknown write address with writes disabled changes nothing.
    wa = 5'bxxxxx;
    wd = 32'hCAFE_F00D;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_regs("we0_x_addr");
    chk("we0_cnt", {16'h0, wr_count}, 32'(m_count));

    // Randomized traffic against the model.
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      we       = ($urandom_range(0, 3) != 0);
      wa       = 5'($urandom_range(0, 31));
      wd       = $urandom;
      ra1      = 5'($urandom_range(0, 31));
      ra2      = ($urandom_range(0, 4) == 0) ? ra1 : 5'($urandom_range(0, 31));
      dbg_addr = 5'($urandom_range(0, 31));
      #1;
      chk("rand_rd1", rd1, m_regs[ra1]);
      chk("rand_rd2", rd2, m_regs[ra2]);
      chk("rand_dbg", dbg_data, m_regs[dbg_addr]);
      @(posedge clk);
      #1;
      model_edge(we, wa, wd);
      chk("rand_cnt", {16'h0, wr_count}, 32'(m_count));
    end
    @(negedge clk);
    we = 1'b0;
    check_all_regs("rand_final");

    // Asynchronous reset mid-cycle with a pending write to register 9.
    do_write(1'b1, 5'd9, 32'h9999_0009);
    dbg_addr = 5'd9;
    #1;
    chk("pre_rst_reg9", dbg_data, 32'h9999_0009);
    @(negedge clk);
    we = 1'b1; wa = 5'd9; wd = 32'h0BAD_0BAD;
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_reg9", dbg_data, 32'h0);
    chk("async_rst_cnt", {16'h0, wr_count}, 32'h0);
    @(posedge clk);
    #1;
    chk("rst_wins_reg9", dbg_data, 32'h0);
    model_reset();
    @(negedge clk);
    we = 1'b0;
    rst = 1'b0;

    // First write after reset is a normal write; then run the counter to wrap.
    ra1 = 5'd1;
    @(negedge clk);
    we = 1'b1; wa = 5'd1; wd = 32'h0;
    @(posedge clk);
    #1;
    model_edge(1'b1, 5'd1, 32'h0);
    chk("first_write_cnt", {16'h0, wr_count}, 32'd1);
    for (int n = 1; n < 65536; n++) begin
      @(negedge clk);
      wd = 32'(n);
      @(posedge clk);
      model_edge(1'b1, 5'd1, 32'(n));
      if (n == 65534) begin
        #1;
        chk("cnt_ffff", {16'h0, wr_count}, 32'h0000_FFFF);
      end
    end
    #1;
    chk("cnt_wrap", {16'h0, wr_count}, 32'(m_count));
    chk("cnt_wrap_zero", {16'h0, wr_count}, 32'h0);
    chk("wrap_reg1", rd1, m_regs[1]);
    @(negedge clk);
    we = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #2_000_000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule : tb_reg_file

`default_nettype wire

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 Parameter DATA_W, default 32: register and data width in bits.
REQ-002 Parameter ADDR_W, default 5: register address width; register count is 2**ADDR_W (32).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 ra1  input  ADDR_W  read address, port 1 (rs field).
REQ-006 ra2  input  ADDR_W  read address, port 2 (rt field).
REQ-007 rd1  output  DATA_W  read data, port 1.
REQ-008 rd2  output  DATA_W  read data, port 2.
REQ-009 we  input  1  write enable from the control unit (RegWrite).
REQ-010 wa  input  ADDR_W  write address (rt/rd/31 from the RegDst mux).
REQ-011 wd  input  DATA_W  write data from the writeback mux (ALU, memory, LUI upper-immediate, PC+4).
REQ-012 dbg_addr  input  ADDR_W  debug/display read address.
REQ-013 dbg_data  output  DATA_W  debug/display read data.
REQ-014 wr_count  output  16  count of committed writes since reset, for the display board.

Function
REQ-015 Reads SHALL be combinational: rd1, rd2 and dbg_data follow their address inputs in the same cycle, with no clock latency.
REQ-016 Address 0 SHALL always read as 0 on every read port, whatever was written to it.
REQ-017 On a rising clk edge with we=1 and wa!=0, register[wa] SHALL take wd.
REQ-018 A write with wa=0 SHALL be discarded and SHALL NOT increment wr_count.
REQ-019 With we=0, no register and no counter SHALL change.
REQ-020 Read during write to the same address: before the edge the read port SHALL return the old value, and after the edge the new value; there is no internal bypass.
REQ-021 Both read ports and the debug port SHALL be fully independent; identical addresses on several ports SHALL return identical data.
REQ-022 wr_count SHALL increment by 1 on every committed write (REQ-017) and wrap from 0xFFFF to 0x0000.
REQ-023 wd SHALL be stored bit-exact, with no sign or zero extension; for example, an LUI result 0xABCD0000 is stored as 0xABCD0000.
REQ-024 X or Z on wa while we=0 SHALL NOT corrupt any register.

Reset
REQ-025 While rst=1, all registers SHALL read 0 and wr_count SHALL be 0, regardless of clk.
REQ-026 rst asserted in the same cycle as a write SHALL win: the write is lost.
REQ-027 After rst is released, the first rising edge with we=1 SHALL perform a normal write.

Structure
REQ-028 The constants REG_NUM=32, DATA_W=32, ADDR_W=5 and ZERO_REG=0 SHALL live in the shared cpu_defs package, used by the decoder and datapath.
REQ-029 reg_file SHALL be a single module with no sub-module; storage is one array of 2**ADDR_W-1 entries, with register 0 implemented as a constant.

Verification
REQ-030 Bench: rst pulse, then read all 32 addresses on ra1, ra2 and dbg -> all 0x00000000, wr_count=0.
REQ-031 Bench: we=1, wa=8, wd=0x12340000 (LUI 0x1234), then ra1=8 -> rd1=0x12340000 from the next cycle, wr_count=1.
REQ-032 Bench: we=1, wa=0, wd=0xFFFFFFFF, then ra2=0 -> rd2=0, wr_count unchanged.
REQ-033 Bench: ra1=ra2=wa=5 holding 0x11, with wd=0x22 and we=1 -> both ports read 0x11 before the edge and 0x22 after it.
REQ-034 Bench: rst asserted mid-cycle with we=1, wa=9 -> register 9=0 asynchronously and the write is lost; 65536 writes after reset -> wr_count wraps to 0.
